// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types, response codes and FSM state encodings for the
// register-file slaves.
package axil_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_ADDR_W = 8;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef logic [1:0]            axi_resp_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_STRB_W-1:0] axi_strb_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-strobe merge: each byte lane takes new data when its strobe is set,
// otherwise keeps the old register contents.
module axil_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic [DATA_WIDTH-1:0]   o_data
);

  always_comb begin
    o_data = i_old;
    for (int k = 0; k < DATA_WIDTH / 8; k++) begin
      if (i_strb[k]) o_data[8*k +: 8] = i_wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite register file slave with byte strobes, hardware-sourced read-only
// registers, per-register write pulses and SLVERR/DECERR responses.
//
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where VALID and READY are both high; a source holds VALID and its payload
// until that edge, and READY never depends combinationally on VALID.
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                  AXI_DATA_WIDTH = 32,
  parameter int                  AXI_ADDR_WIDTH = 8,
  parameter int                  NUM_REGS       = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
  input  logic                               clk,
  input  logic                               areset,
  input  logic [AXI_ADDR_WIDTH-1:0]          S00_AXI_AWADDR,
  input  logic                               S00_AXI_AWVALID,
  output logic                               S00_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]          S00_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        S00_AXI_WSTRB,
  input  logic                               S00_AXI_WVALID,
  output logic                               S00_AXI_WREADY,
  output logic [1:0]                         S00_AXI_BRESP,
  output logic                               S00_AXI_BVALID,
  input  logic                               S00_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]          S00_AXI_ARADDR,
  input  logic                               S00_AXI_ARVALID,
  output logic                               S00_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]          S00_AXI_RDATA,
  output logic [1:0]                         S00_AXI_RRESP,
  output logic                               S00_AXI_RVALID,
  input  logic                               S00_AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                wr_pulse
);

  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);

  wr_state_t                 r_wr_state;
  rd_state_t                 r_rd_state;
  logic                      r_awready;
  logic                      r_wready;
  logic                      r_bvalid;
  axi_resp_t                 r_bresp;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic [AXI_ADDR_WIDTH-1:0] r_awidx;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;
  logic [AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]       r_wr_pulse;
  logic                      r_arready;
  logic                      r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  axi_resp_t                 r_rresp;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic [AXI_ADDR_WIDTH-1:0] w_aw_idx;
  logic [AXI_ADDR_WIDTH-1:0] w_ar_idx;
  logic [AXI_DATA_WIDTH-1:0] w_old;
  logic [AXI_DATA_WIDTH-1:0] w_merged;
  logic [NUM_REGS-1:0]       w_wr_hit;
  axi_resp_t                 w_wr_resp;
  logic [AXI_DATA_WIDTH-1:0] w_rd_data;
  axi_resp_t                 w_rd_resp;

  assign w_aw_hs  = S00_AXI_AWVALID & r_awready;
  assign w_w_hs   = S00_AXI_WVALID & r_wready;
  assign w_ar_hs  = S00_AXI_ARVALID & r_arready;
  assign w_aw_idx = S00_AXI_AWADDR >> ADDR_LSB;
  assign w_ar_idx = S00_AXI_ARADDR >> ADDR_LSB;

  // Decode the captured write index into a one-hot hit and its response.
  always_comb begin
    w_old    = '0;
    w_wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(r_awidx) == i) begin
        w_old       = r_regs[i];
        w_wr_hit[i] = 1'b1;
      end
    end
    if (int'(r_awidx) >= NUM_REGS)       w_wr_resp = RESP_DECERR;
    else if ((w_wr_hit & RO_MASK) != '0) w_wr_resp = RESP_SLVERR;
    else                                 w_wr_resp = RESP_OKAY;
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_ar_idx) == i)
        w_rd_data = RO_MASK[i] ? reg_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : r_regs[i];
    end
    w_rd_resp = (int'(w_ar_idx) >= NUM_REGS) ? RESP_DECERR : RESP_OKAY;
  end

  axil_strb_merge #(.DATA_WIDTH(AXI_DATA_WIDTH)) u_merge (
    .i_old   (w_old),
    .i_wdata (r_wdata),
    .i_strb  (r_wstrb),
    .o_data  (w_merged)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs) begin
            r_awidx   <= w_aw_idx;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata  <= S00_AXI_WDATA;
            r_wstrb  <= S00_AXI_WSTRB;
            r_w_done <= 1'b1;
          end
          // Both halves were captured on earlier edges; READYs are already low.
          if (r_aw_done && r_w_done) begin
            if (w_wr_resp == RESP_OKAY) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i]) r_regs[i] <= w_merged;
              end
              r_wr_pulse <= w_wr_hit;
            end
            r_bresp    <= w_wr_resp;
            r_bvalid   <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_wr_state <= WR_RESP;
          end else begin
            r_awready <= !(r_aw_done || w_aw_hs);
            r_wready  <= !(r_w_done || w_w_hs);
          end
        end
        WR_RESP: begin
          if (S00_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_resp;
            r_rvalid   <= 1'b1;
            r_arready  <= 1'b0;
            r_rd_state <= RD_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (S00_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_regs[g];
    end
  endgenerate

  assign S00_AXI_AWREADY = r_awready;
  assign S00_AXI_WREADY  = r_wready;
  assign S00_AXI_BVALID  = r_bvalid;
  assign S00_AXI_BRESP   = r_bresp;
  assign S00_AXI_ARREADY = r_arready;
  assign S00_AXI_RVALID  = r_rvalid;
  assign S00_AXI_RDATA   = r_rdata;
  assign S00_AXI_RRESP   = r_rresp;
  assign wr_pulse        = r_wr_pulse;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Self-checking bench for axil_regfile_slave: directed scenarios plus random
// traffic checked against an array model of the register file.
module tb_axil_regfile_slave;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0008;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic           clk = 1'b0;
  logic           areset = 1'b1;
  logic [AW-1:0]  awaddr = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [AW-1:0]  araddr = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in = '0;
  logic [NR-1:0]  wr_pulse;

  logic [DW-1:0] m_regs [NR];
  int n_checks = 0;
  int n_fail = 0;

  axil_regfile_slave #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .NUM_REGS       (NR),
    .RO_MASK        (RO)
  ) dut (
    .clk             (clk),
    .areset          (areset),
    .S00_AXI_AWADDR  (awaddr),
    .S00_AXI_AWVALID (awvalid),
    .S00_AXI_AWREADY (awready),
    .S00_AXI_WDATA   (wdata),
    .S00_AXI_WSTRB   (wstrb),
    .S00_AXI_WVALID  (wvalid),
    .S00_AXI_WREADY  (wready),
    .S00_AXI_BRESP   (bresp),
    .S00_AXI_BVALID  (bvalid),
    .S00_AXI_BREADY  (bready),
    .S00_AXI_ARADDR  (araddr),
    .S00_AXI_ARVALID (arvalid),
    .S00_AXI_ARREADY (arready),
    .S00_AXI_RDATA   (rdata),
    .S00_AXI_RRESP   (rresp),
    .S00_AXI_RVALID  (rvalid),
    .S00_AXI_RREADY  (rready),
    .reg_out         (reg_out),
    .reg_in          (reg_in),
    .wr_pulse        (wr_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [DW-1:0] model_read(input int idx);
    if (idx >= NR) return '0;
    if (RO[idx]) return reg_in[idx*DW +: DW];
    return m_regs[idx];
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? '0 : m_regs[i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic axi_write(input int idx, input int lowb, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, input int aw_d, input int w_d,
                           input int b_stall, input string tag);
    logic [1:0] exp_resp;
    logic [NR-1:0] exp_pulse;
    logic [DW-1:0] newv;
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc, lat;
    exp_pulse = '0;
    newv = '0;
    if (idx >= NR) exp_resp = DECERR;
    else if (RO[idx]) exp_resp = SLVERR;
    else begin
      exp_resp = OKAY;
      exp_pulse[idx] = 1'b1;
      newv = m_regs[idx];
      for (int k = 0; k < DW/8; k++) if (strb[k]) newv[8*k +: 8] = data[8*k +: 8];
    end
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_d);
      awaddr  = AW'(idx * 4 + lowb);
      wvalid  = !w_done && (cyc >= w_d);
      wdata   = data;
      wstrb   = strb;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      cyc++;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    n_checks++;
    if (!(aw_done && w_done)) begin
      n_fail++;
      $display("FAIL %s aw/w handshake timeout: aw=%0d w=%0d expected both 1", tag, aw_done, w_done);
      return;
    end
    lat = 0;
    while (!bvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL %s bvalid latency: got %0d expected 1", tag, lat);
    end
    n_checks++;
    if (bresp !== exp_resp) begin
      n_fail++;
      $display("FAIL %s bresp: got %0b expected %0b", tag, bresp, exp_resp);
    end
    n_checks++;
    if (wr_pulse !== exp_pulse) begin
      n_fail++;
      $display("FAIL %s wr_pulse: got %h expected %h", tag, wr_pulse, exp_pulse);
    end
    if (exp_resp == OKAY) m_regs[idx] = newv;
    n_checks++;
    if (reg_out !== model_flat()) begin
      n_fail++;
      $display("FAIL %s reg_out: got %h expected %h", tag, reg_out, model_flat());
    end
    for (int s = 0; s < b_stall; s++) begin
      awvalid = 1'b1; awaddr = AW'(5 * 4); wvalid = 1'b1; wdata = $urandom; wstrb = '1;
      @(posedge clk); #1;
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0 ||
          wr_pulse !== '0) begin
        n_fail++;
        $display("FAIL %s b stall: bvalid=%0b bresp=%0b awready=%0b wready=%0b pulse=%h expected 1 %0b 0 0 0",
                 tag, bvalid, bresp, awready, wready, wr_pulse, exp_resp);
      end
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1 || wr_pulse !== '0) begin
      n_fail++;
      $display("FAIL %s after bresp: bvalid=%0b awready=%0b wready=%0b pulse=%h expected 0 1 1 0",
               tag, bvalid, awready, wready, wr_pulse);
    end
    n_checks++;
    if (reg_out !== model_flat()) begin
      n_fail++;
      $display("FAIL %s reg_out after stall: got %h expected %h", tag, reg_out, model_flat());
    end
  endtask

  task automatic axi_read(input int idx, input int lowb, input int ar_d, input int r_stall,
                          input logic [DW-1:0] exp_data, input logic [1:0] exp_resp,
                          input string tag);
    bit done, fire;
    int cyc;
    done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      arvalid = (cyc >= ar_d);
      araddr  = AW'(idx * 4 + lowb);
      fire    = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
      if (fire) done = 1;
    end
    arvalid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s ar handshake timeout: got 0 expected 1", tag);
      return;
    end
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s read: rvalid=%0b rdata=%h rresp=%0b arready=%0b expected 1 %h %0b 0",
               tag, rvalid, rdata, rresp, arready, exp_data, exp_resp);
    end
    for (int s = 0; s < r_stall; s++) begin
      arvalid = 1'b1; araddr = AW'($urandom_range(0, 63));
      @(posedge clk); #1;
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data || rresp !== exp_resp || arready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s r stall: rvalid=%0b rdata=%h rresp=%0b arready=%0b expected 1 %h %0b 0",
                 tag, rvalid, rdata, rresp, arready, exp_data, exp_resp);
      end
    end
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after rresp: rvalid=%0b arready=%0b expected 0 1", tag, rvalid, arready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (awready !== 0 || wready !== 0 || arready !== 0 || bvalid !== 0 || rvalid !== 0 ||
        bresp !== 0 || rresp !== 0 || rdata !== 0 || reg_out !== '0 || wr_pulse !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: aw=%0b w=%0b ar=%0b bv=%0b rv=%0b rdata=%h expected all 0",
               awready, wready, arready, bvalid, rvalid, rdata);
    end
    areset = 1'b0;
    #1;
    n_checks++;
    if (awready !== 0 || wready !== 0 || arready !== 0) begin
      n_fail++;
      $display("FAIL ready before first edge: %0b%0b%0b expected 000", awready, wready, arready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (awready !== 1 || wready !== 1 || arready !== 1) begin
      n_fail++;
      $display("FAIL ready after first edge: %0b%0b%0b expected 111", awready, wready, arready);
    end
  endtask

  task automatic test_basic();
    axi_write(0, 0, 32'd1488, 4'hF, 0, 0, 0, "basic_wr");
    axi_read(0, 0, 0, 0, 32'd1488, OKAY, "basic_rd");
  endtask

  task automatic test_order();
    axi_write(1, 0, 32'hDEADBEEF, 4'hF, 3, 0, 0, "w_first");
    axi_read(1, 0, 0, 0, 32'hDEADBEEF, OKAY, "w_first_rd");
    axi_write(1, 2, 32'h0, 4'hF, 0, 0, 0, "clear1");
    axi_write(1, 1, 32'hDEADBEEF, 4'hF, 0, 3, 0, "aw_first");
    axi_read(1, 3, 0, 0, 32'hDEADBEEF, OKAY, "aw_first_rd");
  endtask

  task automatic test_strobe();
    axi_write(2, 0, 32'h11223344, 4'hF, 0, 0, 0, "strb_init");
    axi_write(2, 0, 32'hAABBCCDD, 4'b0101, 1, 0, 0, "strb_part");
    axi_read(2, 0, 0, 0, 32'h11BB33DD, OKAY, "strb_rd");
    axi_write(2, 0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, "strb_zero");
    axi_read(2, 0, 0, 0, 32'h11BB33DD, OKAY, "strb_zero_rd");
  endtask

  task automatic test_errors();
    axi_write(NR, 0, 32'h12345678, 4'hF, 0, 0, 0, "decerr_wr");
    axi_read(NR, 0, 0, 0, 32'h0, DECERR, "decerr_rd");
    axi_write(3, 0, 32'hCAFEF00D, 4'hF, 0, 0, 0, "slverr_wr");
    axi_read(3, 0, 0, 0, 32'h00005A5A, OKAY, "ro_rd");
  endtask

  task automatic test_stall();
    axi_write(5, 0, 32'h0BADC0DE, 4'hF, 0, 0, 5, "b_stall");
    axi_read(5, 0, 0, 5, 32'h0BADC0DE, OKAY, "r_stall");
  endtask

  task automatic test_simultaneous();
    axi_write(4, 0, 32'd7, 4'hF, 0, 0, 0, "sim_init");
    fork
      axi_write(4, 0, 32'd9, 4'hF, 0, 0, 0, "sim_wr");
      axi_read(4, 0, 1, 0, 32'd7, OKAY, "sim_rd_old");
    join
    axi_read(4, 0, 0, 0, 32'd9, OKAY, "sim_rd_new");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = $urandom_range(0, NR + 1);
      if ($urandom_range(0, 1) == 1)
        axi_write(idx, $urandom_range(0, 3), $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rand_wr");
      else
        axi_read(idx, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 model_read(idx), (idx >= NR) ? DECERR : OKAY, "rand_rd");
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    axi_write(6, 0, 32'h66666666, 4'hF, 0, 0, 0, "mid_init");
    awvalid = 1'b1; awaddr = AW'(7 * 4); wvalid = 1'b1; wdata = 32'h77777777; wstrb = '1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid bvalid before reset: got %0b expected 1", bvalid);
    end
    areset = 1'b1;
    #2;
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    n_checks++;
    if (bvalid !== 0 || reg_out !== '0 || wr_pulse !== '0 || awready !== 0 || wready !== 0) begin
      n_fail++;
      $display("FAIL mid reset: bvalid=%0b reg_out=%h pulse=%h expected 0 0 0", bvalid, reg_out, wr_pulse);
    end
    @(posedge clk); #1;
    areset = 1'b0;
    @(posedge clk); #1;
    axi_read(0, 0, 0, 0, 32'h0, OKAY, "post_reset_rd0");
    axi_read(4, 0, 0, 0, 32'h0, OKAY, "post_reset_rd4");
    axi_read(3, 0, 0, 0, 32'h00005A5A, OKAY, "post_reset_ro");
  endtask

  initial begin
    for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = $urandom;
    reg_in[3*DW +: DW] = 32'h00005A5A;
    test_reset();
    test_basic();
    test_order();
    test_strobe();
    test_errors();
    test_stall();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
- Parametrised AXI4-Lite slave register file; successor to the fixed single-slave top-level register block.
- Adds configurable register count and data width, byte strobes, and independent AW/W arrival order.
- Adds read-only registers sourced from hardware, per-register write pulses, and decode/slave-error responses.
- Sits between the S00 AXI-Lite interconnect port and user logic.

Parameters:
- AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64.
- AXI_ADDR_WIDTH, 8, byte address width.
- NUM_REGS, 16, number of registers; 1..2**(AXI_ADDR_WIDTH-ADDR_LSB).
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, with its value taken from reg_in.

Ports:
- clk  in  1  clock.
- areset  in  1  reset, asynchronous, active-high.
- S00_AXI_AWADDR/AWVALID/AWREADY  in/in/out  AXI_ADDR_WIDTH/1/1  write address channel.
- S00_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel.
- S00_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S00_AXI_ARADDR/ARVALID/ARREADY  in/in/out  AXI_ADDR_WIDTH/1/1  read address channel.
- S00_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  AXI_DATA_WIDTH/2/1/1  read data channel.
- reg_out  out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents; register i occupies slice i.
- reg_in  in  NUM_REGS*AXI_DATA_WIDTH  hardware values for read-only registers.
- wr_pulse  out  NUM_REGS  one-cycle pulse on each OKAY write to register i.

Behaviour:
- Reset: all registers, reg_out, wr_pulse, BVALID, RVALID, RDATA, BRESP and RRESP go to 0, and AWREADY, WREADY and ARREADY go to 0. The three READY outputs are registered and rise on the first clk edge after areset deasserts. Reset asserted mid-transaction aborts it; no register update occurs.
- Addressing: ADDR_LSB = log2(AXI_DATA_WIDTH/8). Register index = addr >> ADDR_LSB. Low address bits are ignored.
- Write FSM states are WR_IDLE and WR_RESP.
  - In WR_IDLE, AWREADY=1 until AW is captured and WREADY=1 until W is captured. AW and W may arrive in the same cycle or in either order.
  - When both are captured, the next edge commits the write, raises BVALID with BRESP, drops both READYs and enters WR_RESP. Latency from the final handshake edge to BVALID is 1 cycle.
  - In WR_RESP, BVALID/BRESP are held until BREADY. On that edge the FSM returns to WR_IDLE, with AWREADY and WREADY rising on that same edge.
  - Commit: byte k of register i is updated iff WSTRB[k]. WSTRB=0 is OKAY with no change, and wr_pulse still fires.
  - Index >= NUM_REGS: BRESP=2'b11 (DECERR), no update, no pulse.
  - Index is read-only: BRESP=2'b10 (SLVERR), no update, no pulse.
  - Otherwise BRESP=2'b00, and wr_pulse[i]=1 for exactly the commit cycle.
- Read FSM states are RD_IDLE and RD_DATA.
  - In RD_IDLE, ARREADY=1. On the AR handshake edge, RDATA/RRESP are latched, RVALID=1 and the FSM enters RD_DATA. Latency is 1 cycle.
  - RDATA = reg_in slice for read-only registers, else the register value. Index >= NUM_REGS gives RDATA=0, RRESP=DECERR. Read-only reads are OKAY.
  - In RD_DATA, ARREADY=0 and RDATA/RRESP/RVALID are held until RREADY. On that edge the FSM returns to RD_IDLE.
- Channels are independent. A read and a write to the same register resolving on the same edge: the read returns the pre-write value.
- Outstanding depth is 1 per direction. VALID without READY is simply stalled.

Decomposition:
- Package axil_pkg:
  - types axi_resp_t and the widths of axi_data_t/axi_addr_t/axi_strb_t;
  - constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - enums for the write and read FSM states.
- Sub-module axil_strb_merge: combinational merge of old data, WDATA and WSTRB into the new word; reused by future slaves.

Test Plan:
- Reset, release, then write index 0 = 1488 with WSTRB all-ones, AW and W in the same cycle -> BVALID 1 cycle later, BRESP=0, wr_pulse[0] one cycle, reg_out slice0=1488. Read index 0 -> RDATA=1488, RRESP=0.
- W issued 3 cycles before AW, then the reverse order; index 1 data 0xDEADBEEF -> both orders commit identically, BRESP=0.
- Register 2=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> readback 0x11BB33DD.
- Write index NUM_REGS -> BRESP=DECERR, no wr_pulse. RO_MASK bit3=1, reg_in slice3=0x5A5A: write index 3 -> SLVERR, readback 0x5A5A with OKAY.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable, READYs low, no new handshakes.
- Simultaneous AR and AW+W to index 4 (old 7, new 9) -> RDATA=7, a later read returns 9. areset pulsed during WR_RESP -> BVALID=0 and all registers 0.
